// File: rtl/csr_row_scheduler.sv
// csr_row_scheduler
// Walks the CSR row-pointer array of a sparse operand and issues one nonzero
// index per downstream handshake. Each output row is framed with nz_first /
// nz_last on the issued indices and closed with a row_commit pulse (flagged
// row_empty when the row held no nonzeros).
//
// Handshake (nz_*): a nonzero transfers on a rising clk edge where
// nz_valid && nz_ready. Once nz_valid is raised, nz_valid, nz_addr, nz_first
// and nz_last stay constant until that transfer happens; nz_valid never
// depends on nz_ready. Only abort or reset can withdraw an offered index.
//
// Row-pointer RAM: rp_rd/rp_addr in one cycle, rp_data is sampled in the
// following cycle. row_ptr[r+1] becomes the begin pointer of row r+1, so
// every row-pointer entry is read exactly once per traversal.
module csr_row_scheduler #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  num_rows,
  output logic              rp_rd,
  output logic [ROW_W:0]    rp_addr,
  input  logic [ADDR_W-1:0] rp_data,
  output logic              nz_valid,
  input  logic              nz_ready,
  output logic [ADDR_W-1:0] nz_addr,
  output logic              nz_first,
  output logic              nz_last,
  output logic [ROW_W-1:0]  row_idx,
  output logic              row_commit,
  output logic              row_empty,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD0    = 3'd1,
    S_LAT0   = 3'd2,
    S_RDN    = 3'd3,
    S_LATN   = 3'd4,
    S_ISSUE  = 3'd5,
    S_COMMIT = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ROW_W-1:0]  rows_q;   // latched row count for this traversal
  logic [ROW_W-1:0]  row_q;    // row currently being walked
  logic [ADDR_W-1:0] beg_ptr;  // row_ptr[row_q]
  logic [ADDR_W-1:0] end_ptr;  // row_ptr[row_q+1]
  logic [ADDR_W-1:0] nz_ptr;   // next nonzero to offer downstream
  logic              err_q;

  logic              start_ok;
  logic              ptr_last;
  logic              last_row;
  logic              row_has_nz;
  logic [ROW_W:0]    next_rp_addr;

  // A start is taken only from IDLE, and never in the same cycle as abort.
  assign start_ok     = (state == S_IDLE) && start && !abort;
  // Modulo-2^ADDR_W increment: the index one past nz_ptr closes the row.
  assign ptr_last     = ((nz_ptr + ADDR_W'(1)) == end_ptr);
  assign last_row     = (row_q == (rows_q - ROW_W'(1)));
  // Only a strictly increasing pointer pair describes a row with nonzeros.
  assign row_has_nz   = (rp_data > beg_ptr);
  assign next_rp_addr = {1'b0, row_q} + (ROW_W+1)'(1);

  assign busy    = (state != S_IDLE);
  assign row_idx = row_q;
  assign err     = err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and all Moore outputs; abort overrides every transition.
  always_comb begin
    state_nxt  = state;
    rp_rd      = 1'b0;
    rp_addr    = '0;
    nz_valid   = 1'b0;
    nz_addr    = '0;
    nz_first   = 1'b0;
    nz_last    = 1'b0;
    row_commit = 1'b0;
    row_empty  = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_rows == '0) ? S_DONE : S_RD0;
        end
      end
      S_RD0: begin
        rp_rd     = 1'b1;
        rp_addr   = '0;
        state_nxt = S_LAT0;
      end
      S_LAT0: begin
        state_nxt = S_RDN;
      end
      S_RDN: begin
        rp_rd     = 1'b1;
        rp_addr   = next_rp_addr;
        state_nxt = S_LATN;
      end
      S_LATN: begin
        state_nxt = row_has_nz ? S_ISSUE : S_COMMIT;
      end
      S_ISSUE: begin
        nz_valid = 1'b1;
        nz_addr  = nz_ptr;
        nz_first = (nz_ptr == beg_ptr);
        nz_last  = ptr_last;
        if (nz_ready && ptr_last) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        row_commit = 1'b1;
        // Equal pointers (empty) and reversed pointers (err) both carry no data.
        row_empty  = (end_ptr <= beg_ptr);
        state_nxt  = last_row ? S_DONE : S_RDN;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // Traversal datapath: row counter, row pointers, issue pointer, sticky err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q  <= '0;
      row_q   <= '0;
      beg_ptr <= '0;
      end_ptr <= '0;
      nz_ptr  <= '0;
      err_q   <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            rows_q <= num_rows;
            row_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        S_LAT0: begin
          beg_ptr <= rp_data;
        end
        S_LATN: begin
          end_ptr <= rp_data;
          nz_ptr  <= beg_ptr;
          if (rp_data < beg_ptr) begin
            err_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (nz_ready) begin
            nz_ptr <= nz_ptr + ADDR_W'(1);
          end
        end
        S_COMMIT: begin
          beg_ptr <= end_ptr;
          if (!last_row) begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_row_scheduler.sv
// tb_csr_row_scheduler
// Drives CSR traversals against a row-pointer RAM model and checks every
// observed nonzero, row commit and done pulse against an event list computed
// directly from the row-pointer contents.
module tb_csr_row_scheduler;

  localparam int ADDR_W = 11;
  localparam int ROW_W  = 8;
  localparam int W      = 24;

  // ---------------------------------------------------------------- clock/reset
  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ROW_W-1:0]  num_rows;
  logic              rp_rd;
  logic [ROW_W:0]    rp_addr;
  logic [ADDR_W-1:0] rp_data;
  logic              nz_valid;
  logic              nz_ready;
  logic [ADDR_W-1:0] nz_addr;
  logic              nz_first;
  logic              nz_last;
  logic [ROW_W-1:0]  row_idx;
  logic              row_commit;
  logic              row_empty;
  logic              busy;
  logic              done;
  logic              err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csr_row_scheduler #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_rows(num_rows),
    .rp_rd(rp_rd), .rp_addr(rp_addr), .rp_data(rp_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_addr(nz_addr),
    .nz_first(nz_first), .nz_last(nz_last), .row_idx(row_idx),
    .row_commit(row_commit), .row_empty(row_empty), .busy(busy),
    .done(done), .err(err)
  );

  // Row-pointer RAM: data appears the cycle after the read strobe.
  logic [ADDR_W-1:0] rp_mem [0:511];
  always @(posedge clk) begin
    if (rp_rd) rp_data <= rp_mem[rp_addr];
  end

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rp_rd, rp_addr, nz_valid, nz_addr, nz_first, nz_last, row_idx,
                row_commit, row_empty, busy, done, err});
  endfunction

  // Event word: {kind[1:0], row[7:0], addr[10:0], first, last, empty}
  // kind 1 = nonzero transfer, 2 = row commit, 3 = done
  function automatic logic [W-1:0] mk_ev(input logic [1:0] kind, input logic [7:0] row,
                                         input logic [10:0] a, input logic f,
                                         input logic l, input logic e);
    return {kind, row, a, f, l, e};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q [$];
  int rd_cnt = 0;
  int stall_cnt = 0;
  int commit_cnt = 0;
  int done_cnt = 0;

  task automatic sb_match(input string tag, input logic [W-1:0] ev);
    if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 64'(ev), 64'h0);
    else check_eq(tag, 64'(ev), 64'(exp_q.pop_front()));
  endtask

  // Reference: expected event stream from row_ptr[0..n] using plain integer rules.
  task automatic build_model(input int n, output int nz_tot, output logic err_e);
    logic [10:0] b;
    logic [10:0] e;
    nz_tot = 0;
    err_e  = 1'b0;
    for (int r = 0; r < n; r++) begin
      b = rp_mem[r];
      e = rp_mem[r+1];
      if (e > b) begin
        for (int a = int'(b); a < int'(e); a++)
          exp_q.push_back(mk_ev(2'd1, 8'(r), 11'(a), a == int'(b), a + 1 == int'(e), 1'b0));
        nz_tot += int'(e) - int'(b);
        exp_q.push_back(mk_ev(2'd2, 8'(r), 11'd0, 1'b0, 1'b0, 1'b0));
      end else begin
        if (e < b) err_e = 1'b1;
        exp_q.push_back(mk_ev(2'd2, 8'(r), 11'd0, 1'b0, 1'b0, 1'b1));
      end
    end
    exp_q.push_back(mk_ev(2'd3, 8'd0, 11'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_a;
  logic              prev_f;
  logic              prev_l;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check_eq("stall_hold", 64'({nz_valid, nz_first, nz_last, nz_addr}),
                   64'({1'b1, prev_f, prev_l, prev_a}));
        prev_stall = nz_valid && !nz_ready;
        prev_a = nz_addr;
        prev_f = nz_first;
        prev_l = nz_last;
        if (nz_valid && nz_ready)
          sb_match("nz", mk_ev(2'd1, row_idx, nz_addr, nz_first, nz_last, 1'b0));
        if (row_commit) begin
          commit_cnt++;
          sb_match("commit", mk_ev(2'd2, row_idx, 11'd0, 1'b0, 1'b0, row_empty));
        end
        if (done) begin
          done_cnt++;
          sb_match("done", mk_ev(2'd3, 8'd0, 11'd0, 1'b0, 1'b0, 1'b0));
        end
        if (rp_rd) rd_cnt++;
        if (nz_valid && !nz_ready) stall_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // ready_mode: 0 always ready, 1 random, 2 hold ready low 3 cycles on index 3
  int ready_mode = 0;

  initial begin
    int hold;
    hold = 0;
    nz_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: nz_ready = 1'b1;
        1: nz_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (nz_valid && nz_addr == 11'd3 && hold < 3) begin
            nz_ready = 1'b0;
            hold++;
          end else begin
            nz_ready = 1'b1;
            if (!(nz_valid && nz_addr == 11'd3)) hold = 0;
          end
        end
      endcase
    end
  end

  task automatic load_basic();
    rp_mem[0] = 11'd0; rp_mem[1] = 11'd2; rp_mem[2] = 11'd2; rp_mem[3] = 11'd5;
  endtask

  task automatic load_random(input int n);
    rp_mem[0] = 11'($urandom_range(0, 2047));
    for (int k = 1; k <= n; k++) begin
      if ($urandom_range(0, 7) == 0) rp_mem[k] = rp_mem[k-1] - 11'($urandom_range(1, 3));
      else rp_mem[k] = rp_mem[k-1] + 11'($urandom_range(0, 4));
    end
  endtask

  // One traversal. start_again_at/abort_at are cycle numbers after the start
  // edge (-1 = unused); reset_at_addr resets while that index is offered.
  task automatic run_job(input int n, input int mode, input int start_again_at,
                         input int abort_at, input int reset_at_addr);
    int   nz_tot, cnt, rd0, st0, dn0, cm0, exp_cyc;
    logic err_e;
    logic seen_done;
    exp_q.delete();
    build_model(n, nz_tot, err_e);
    ready_mode = mode;
    rd0 = rd_cnt; st0 = stall_cnt; dn0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_rows = 8'(n);
    cnt = 0;
    seen_done = 1'b0;
    while (!seen_done && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("err_cleared", 64'(err), 64'd0);
      end
      if (cnt == start_again_at) start = 1'b1;
      if (cnt == start_again_at + 1) start = 1'b0;
      if (reset_at_addr >= 0 && nz_valid && nz_addr == 11'(reset_at_addr)) begin
        reset = 1'b1;
        #1;
        check_eq("reset_mid_outs", all_outs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (cnt == abort_at) abort = 1'b1;
      if (cnt == abort_at + 1) begin
        abort = 1'b0;
        exp_q.delete();
        check_eq("abort_idle", 64'({busy, nz_valid, rp_rd}), 64'd0);
        cm0 = commit_cnt;
        repeat (10) @(negedge clk);
        check_eq("abort_no_done", 64'(done_cnt), 64'(dn0));
        check_eq("abort_no_commit", 64'(commit_cnt), 64'(cm0));
        check_eq("abort_busy", 64'(busy), 64'd0);
        return;
      end
      if (done) seen_done = 1'b1;
    end
    check_eq("done_seen", 64'(seen_done), 64'd1);
    exp_cyc = (n == 0) ? 1 : 3 + 3 * n + nz_tot + (stall_cnt - st0);
    if (seen_done) check_eq("done_cycle", 64'(cnt), 64'(exp_cyc));
    @(negedge clk);
    check_eq("busy_after_done", 64'(busy), 64'd0);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    check_eq("err_final", 64'(err), 64'(err_e));
    check_eq("rp_reads", 64'(rd_cnt - rd0), 64'((n == 0) ? 0 : n + 1));
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int s0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_rows = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_outs", all_outs(), 64'd0);

    // Basic three-row matrix with an empty middle row.
    load_basic();
    run_job(3, 0, -1, -1, -1);

    // Same data, downstream stalls on index 3.
    s0 = stall_cnt;
    run_job(3, 2, -1, -1, -1);
    check_eq("stall_cycles", 64'(stall_cnt - s0), 64'd3);

    // Zero rows: done only.
    run_job(0, 0, -1, -1, -1);

    // Reversed pointers flag err; next start clears it.
    rp_mem[0] = 11'd4; rp_mem[1] = 11'd2;
    run_job(1, 0, -1, -1, -1);
    load_basic();
    run_job(3, 0, -1, -1, -1);

    // Reset while index 3 is offered, then a clean rerun.
    run_job(3, 0, -1, -1, 3);
    run_job(3, 0, -1, -1, -1);

    // Start while busy is ignored; abort mid-traversal; clean run afterwards.
    run_job(3, 0, 5, -1, -1);
    run_job(3, 0, -1, 8, -1);
    run_job(3, 1, -1, -1, -1);

    // Randomized traversals with random backpressure and wrapping pointers.
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 10);
      load_random(n);
      run_job(n, 1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
